// File: rtl/mem_arbiter.sv
// Two-client line-memory arbiter (D-cache = client 0, I-cache = client 1).
// Round-robin ties by default; define MEM_ARB_FIXED_PRIO_EN for fixed client-0 priority.
module mem_arbiter #(
   parameter int LINE_ADDR_LEN = 4,
   parameter int MEM_ADDR_LEN  = 8,
   localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [MEM_ADDR_LEN-1:0]          c0_addr,
   input  logic                             c0_rd_req,
   input  logic                             c0_wr_req,
   input  logic [LINE_SIZE-1:0][31:0]       c0_wr_line,
   output logic [LINE_SIZE-1:0][31:0]       c0_rd_line,
   output logic                             c0_gnt,
   input  logic [MEM_ADDR_LEN-1:0]          c1_addr,
   input  logic                             c1_rd_req,
   input  logic                             c1_wr_req,
   input  logic [LINE_SIZE-1:0][31:0]       c1_wr_line,
   output logic [LINE_SIZE-1:0][31:0]       c1_rd_line,
   output logic                             c1_gnt,
   output logic [MEM_ADDR_LEN-1:0]          mem_addr,
   output logic                             mem_rd_req,
   output logic                             mem_wr_req,
   output logic [LINE_SIZE-1:0][31:0]       mem_wr_line,
   input  logic [LINE_SIZE-1:0][31:0]       mem_rd_line,
   input  logic                             mem_gnt,
   output logic [1:0]                       owner
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t state;
   logic   req0;
   logic   req1;

   assign req0 = c0_rd_req | c0_wr_req;
   assign req1 = c1_rd_req | c1_wr_req;

`ifndef MEM_ARB_FIXED_PRIO_EN
   logic last_winner;
`endif

   // Any exit from OWNx goes through IDLE, which forces the one-cycle request gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_winner <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                  state <= OWN0;
`else
                  if (last_winner) begin
                     state       <= OWN0;
                     last_winner <= 1'b0;
                  end else begin
                     state       <= OWN1;
                     last_winner <= 1'b1;
                  end
`endif
               end else if (req0) begin
                  state <= OWN0;
               end else if (req1) begin
                  state <= OWN1;
               end
            end
            OWN0: if (mem_gnt || !req0) state <= IDLE;
            OWN1: if (mem_gnt || !req1) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A write wins over a simultaneous read from the same owner.
   always_comb begin
      mem_addr    = '0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_wr_line = '0;
      c0_gnt      = 1'b0;
      c1_gnt      = 1'b0;
      unique case (state)
         OWN0: begin
            mem_addr    = c0_addr;
            mem_wr_req  = c0_wr_req;
            mem_rd_req  = c0_rd_req & ~c0_wr_req;
            mem_wr_line = c0_wr_line;
            c0_gnt      = mem_gnt;
         end
         OWN1: begin
            mem_addr    = c1_addr;
            mem_wr_req  = c1_wr_req;
            mem_rd_req  = c1_rd_req & ~c1_wr_req;
            mem_wr_line = c1_wr_line;
            c1_gnt      = mem_gnt;
         end
         default: begin
         end
      endcase
   end

   assign c0_rd_line = mem_rd_line;
   assign c1_rd_line = mem_rd_line;
   assign owner      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

   typedef logic [15:0][31:0] line_t;

   logic       clk;
   logic       rst;
   logic [7:0] c0_addr, c1_addr, mem_addr;
   logic       c0_rd_req, c0_wr_req, c1_rd_req, c1_wr_req;
   line_t      c0_wr_line, c1_wr_line, c0_rd_line, c1_rd_line;
   line_t      mem_wr_line, mem_rd_line;
   logic       c0_gnt, c1_gnt, mem_rd_req, mem_wr_req, mem_gnt;
   logic [1:0] owner;

   int n_cmp = 0;
   int n_bad = 0;

   // model: current owner (-1 none) and the client that takes the next tie
   int m_own = -1;
   int tie_next = 0;

   mem_arbiter #(.LINE_ADDR_LEN(4), .MEM_ADDR_LEN(8)) dut (
      .clk(clk), .rst(rst),
      .c0_addr(c0_addr), .c0_rd_req(c0_rd_req), .c0_wr_req(c0_wr_req),
      .c0_wr_line(c0_wr_line), .c0_rd_line(c0_rd_line), .c0_gnt(c0_gnt),
      .c1_addr(c1_addr), .c1_rd_req(c1_rd_req), .c1_wr_req(c1_wr_req),
      .c1_wr_line(c1_wr_line), .c1_rd_line(c1_rd_line), .c1_gnt(c1_gnt),
      .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < 16; i++) l[i] = $urandom;
      return l;
   endfunction

   function automatic void model_step();
      bit req [2];
      req[0] = c0_rd_req | c0_wr_req;
      req[1] = c1_rd_req | c1_wr_req;
      if (m_own < 0) begin
         if (req[0] && req[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            m_own = 0;
`else
            m_own = tie_next;
            tie_next = 1 - tie_next;
`endif
         end else if (req[0]) m_own = 0;
         else if (req[1]) m_own = 1;
      end else if (mem_gnt || !req[m_own]) begin
         m_own = -1;
      end
   endfunction

   task automatic model_reset();
      m_own = -1;
      tie_next = 0;
   endtask

   // advance one clock, update the model from pre-edge inputs, land at edge+1
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
   endtask

   always @(negedge clk) begin : cmp
      logic [1:0] eo;
      logic       erd, ewr, eg0, eg1;
      eo = 2'b00; erd = 1'b0; ewr = 1'b0; eg0 = 1'b0; eg1 = 1'b0;
      if (m_own == 0) begin
         eo = 2'b01; ewr = c0_wr_req; erd = c0_rd_req & ~c0_wr_req; eg0 = mem_gnt;
         chk("m_addr0", 64'(mem_addr), 64'(c0_addr));
         chk("m_line0", 64'(mem_wr_line == c0_wr_line), 64'd1);
      end else if (m_own == 1) begin
         eo = 2'b10; ewr = c1_wr_req; erd = c1_rd_req & ~c1_wr_req; eg1 = mem_gnt;
         chk("m_addr1", 64'(mem_addr), 64'(c1_addr));
         chk("m_line1", 64'(mem_wr_line == c1_wr_line), 64'd1);
      end
      if (rst) begin
         chk("rst_addr", 64'(mem_addr), 64'd0);
         chk("rst_line", 64'(mem_wr_line == '0), 64'd1);
      end
      chk("m_owner", 64'(owner), 64'(eo));
      chk("m_rd_req", 64'(mem_rd_req), 64'(erd));
      chk("m_wr_req", 64'(mem_wr_req), 64'(ewr));
      chk("m_gnt0", 64'(c0_gnt), 64'(eg0));
      chk("m_gnt1", 64'(c1_gnt), 64'(eg1));
      chk("bcast0", 64'(c0_rd_line == mem_rd_line), 64'd1);
      chk("bcast1", 64'(c1_rd_line == mem_rd_line), 64'd1);
   end

   task automatic own_chk(input string nm, input logic [1:0] o,
                          input logic [7:0] a, input bit wr);
      tick();
      @(negedge clk);
      chk({nm, "_owner"}, 64'(owner), 64'(o));
      chk({nm, "_addr"}, 64'(mem_addr), 64'(a));
      chk({nm, "_wr"}, 64'(mem_wr_req), 64'(wr));
      chk({nm, "_rd"}, 64'(mem_rd_req), 64'(!wr));
   endtask

   task automatic gnt_chk(input string nm, input int who, input int lat);
      repeat (lat) tick();
      tick();
      mem_gnt = 1'b1;
      @(negedge clk);
      chk({nm, "_g0"}, 64'(c0_gnt), 64'(who == 0));
      chk({nm, "_g1"}, 64'(c1_gnt), 64'(who == 1));
      tick();
      mem_gnt = 1'b0;
   endtask

   task automatic idle_chk(input string nm);
      @(negedge clk);
      chk({nm, "_idle_owner"}, 64'(owner), 64'd0);
      chk({nm, "_idle_req"}, 64'({mem_rd_req, mem_wr_req}), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      c0_addr = '0; c1_addr = '0;
      c0_rd_req = 0; c0_wr_req = 0; c1_rd_req = 0; c1_wr_req = 0;
      c0_wr_line = '0; c1_wr_line = '0; mem_rd_line = '0; mem_gnt = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_reqs", 64'({mem_rd_req, mem_wr_req, c0_gnt, c1_gnt}), 64'd0);
      tick();
      rst = 1'b0;

      // T1 solo read, ~50 cycle memory latency
      c0_rd_req = 1; c0_addr = 8'h2A;
      own_chk("t1", 2'b01, 8'h2A, 0);
      gnt_chk("t1", 0, 48);
      c0_rd_req = 0;
      idle_chk("t1");
      // spurious gnt while idle
      tick();
      mem_gnt = 1;
      @(negedge clk);
      chk("spur_gnt", 64'({c0_gnt, c1_gnt}), 64'd0);
      tick();
      mem_gnt = 0;
      @(negedge clk);
      chk("spur_owner", 64'(owner), 64'd0);

      // T2 ties
      tick();
      c0_rd_req = 1; c0_addr = 8'h11;
      c1_rd_req = 1; c1_addr = 8'h22;
      own_chk("t2a", 2'b01, 8'h11, 0);
      gnt_chk("t2a", 0, 2);
      c0_rd_req = 0;
      idle_chk("t2a");
      own_chk("t2b", 2'b10, 8'h22, 0);
      gnt_chk("t2b", 1, 1);
      c0_rd_req = 1;
      idle_chk("t2b");
`ifdef MEM_ARB_FIXED_PRIO_EN
      own_chk("t2c", 2'b01, 8'h11, 0);
      gnt_chk("t2c", 0, 1);
`else
      own_chk("t2c", 2'b10, 8'h22, 0);
      gnt_chk("t2c", 1, 1);
`endif
      c0_rd_req = 0; c1_rd_req = 0;
      idle_chk("t2c");

      // T3 write-back then refill, with c1 competing
      tick();
      c0_wr_req = 1; c0_addr = 8'h13; c0_wr_line = rand_line();
      c1_rd_req = 1; c1_addr = 8'h80;
      own_chk("t3a", 2'b01, 8'h13, 1);
      chk("t3a_line", 64'(mem_wr_line == c0_wr_line), 64'd1);
      gnt_chk("t3a", 0, 3);
      c0_wr_req = 0; c0_rd_req = 1; c0_addr = 8'h57;
      idle_chk("t3a");
`ifdef MEM_ARB_FIXED_PRIO_EN
      own_chk("t3b", 2'b01, 8'h57, 0);
      gnt_chk("t3b", 0, 2);
      c0_rd_req = 0;
      idle_chk("t3b");
      own_chk("t3c", 2'b10, 8'h80, 0);
      gnt_chk("t3c", 1, 2);
      c1_rd_req = 0;
`else
      own_chk("t3b", 2'b10, 8'h80, 0);
      gnt_chk("t3b", 1, 2);
      c1_rd_req = 0;
      idle_chk("t3b");
      own_chk("t3c", 2'b01, 8'h57, 0);
      gnt_chk("t3c", 0, 2);
      c0_rd_req = 0;
`endif
      idle_chk("t3c");

      // T4 abort three cycles into OWN1
      tick();
      c1_rd_req = 1; c1_addr = 8'h44;
      own_chk("t4", 2'b10, 8'h44, 0);
      repeat (2) tick();
      c1_rd_req = 0;
      #1;
      chk("t4_drop_rd", 64'(mem_rd_req), 64'd0);
      chk("t4_drop_g1", 64'(c1_gnt), 64'd0);
      tick();
      idle_chk("t4");

      // T5 async reset mid-transaction
      tick();
      c0_rd_req = 1; c0_addr = 8'h66;
      own_chk("t5", 2'b01, 8'h66, 0);
      tick();
      #1;
      rst = 1;
      model_reset();
      #1;
      chk("t5_rst_owner", 64'(owner), 64'd0);
      chk("t5_rst_rd", 64'(mem_rd_req), 64'd0);
      c0_rd_req = 0;
      repeat (2) tick();
      rst = 0;
      c1_rd_req = 1; c1_addr = 8'h77;
      own_chk("t5b", 2'b10, 8'h77, 0);
      gnt_chk("t5b", 1, 1);
      c1_rd_req = 0;
      idle_chk("t5b");

      // T6 continuous requests from both clients
      tick();
      c0_rd_req = 1; c0_addr = 8'h90;
      c1_rd_req = 1; c1_addr = 8'hA0;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         own_chk("t6", 2'b01, 8'h90, 0);
         gnt_chk("t6", 0, 1);
`else
         if (k % 2 == 0) begin
            own_chk("t6", 2'b01, 8'h90, 0);
            gnt_chk("t6", 0, 1);
         end else begin
            own_chk("t6", 2'b10, 8'hA0, 0);
            gnt_chk("t6", 1, 1);
         end
`endif
         idle_chk("t6");
      end
      c0_rd_req = 0; c1_rd_req = 0;

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         mem_gnt = ($urandom % 5 == 0);
         mem_rd_line = rand_line();
         if (!(c0_rd_req | c0_wr_req)) begin
            if ($urandom % 4 == 0) begin
               c0_rd_req = $urandom % 2;
               c0_wr_req = ($urandom % 3 == 0) | !c0_rd_req;
               c0_addr = 8'($urandom);
               c0_wr_line = rand_line();
            end
         end else if ($urandom % 12 == 0) begin
            c0_rd_req = 0; c0_wr_req = 0;
         end else if ($urandom % 8 == 0) begin
            c0_addr = 8'($urandom);
         end
         if (!(c1_rd_req | c1_wr_req)) begin
            if ($urandom % 4 == 0) begin
               c1_rd_req = $urandom % 2;
               c1_wr_req = ($urandom % 3 == 0) | !c1_rd_req;
               c1_addr = 8'($urandom);
               c1_wr_line = rand_line();
            end
         end else if ($urandom % 12 == 0) begin
            c1_rd_req = 0; c1_wr_req = 0;
         end else if ($urandom % 8 == 0) begin
            c1_addr = 8'($urandom);
         end
      end
      c0_rd_req = 0; c0_wr_req = 0; c1_rd_req = 0; c1_wr_req = 0; mem_gnt = 0;
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
